// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin scalar/vector arbiter for the shared RAM data port
// Grants in IDLE only; vector bursts walk base+i*stride one element per accepted cycle.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int VLEN_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  s_req,
  input  logic                  s_we,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_gnt,
  output logic                  s_rvalid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  v_req,
  input  logic                  v_we,
  input  logic [ADDR_WIDTH-1:0] v_base,
  input  logic [ADDR_WIDTH-1:0] v_stride,
  input  logic [VLEN_WIDTH-1:0] v_len,
  output logic                  v_gnt,
  input  logic                  v_wvalid,
  input  logic [DATA_WIDTH-1:0] v_wdata,
  output logic                  v_wready,
  output logic                  v_rvalid,
  output logic [DATA_WIDTH-1:0] v_rdata,
  output logic                  v_done,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_src,
  input  logic [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, SCALAR, VBURST, VDRAIN} state_t;

  localparam logic [VLEN_WIDTH-1:0] LP_ONE = VLEN_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last_vec;
  logic                  r_s_we;
  logic [ADDR_WIDTH-1:0] r_s_addr;
  logic [DATA_WIDTH-1:0] r_s_wdata;
  logic                  r_v_we;
  logic [ADDR_WIDTH-1:0] r_v_addr;
  logic [ADDR_WIDTH-1:0] r_v_stride;
  logic [VLEN_WIDTH-1:0] r_v_len;
  logic [VLEN_WIDTH-1:0] r_v_cnt;
  logic                  r_s_pend;
  logic                  r_v_pend;
  logic                  r_zdone;
  logic                  w_grant_s;
  logic                  w_grant_v;
  logic                  w_issue;
  logic                  w_last;

  assign w_last = (r_v_cnt == r_v_len - LP_ONE);

  // Everything driven from state is held off while reset is low so nothing leaks mid-abort.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_s   = 1'b0;
    w_grant_v   = 1'b0;
    w_issue     = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_src     = '0;
    v_wready    = 1'b0;
    if (rst_n_in) begin
      case (r_state)
        IDLE: begin
          if (s_req && (!v_req || r_last_vec)) begin
            w_grant_s   = 1'b1;
            w_state_nxt = SCALAR;
          end else if (v_req) begin
            w_grant_v = 1'b1;
            if (v_len != '0) w_state_nxt = VBURST;
          end
        end
        SCALAR: begin
          mem_addr    = r_s_addr;
          mem_wr      = r_s_we;
          mem_src     = r_s_wdata;
          w_state_nxt = IDLE;
        end
        VBURST: begin
          mem_addr = r_v_addr;
          if (r_v_we) begin
            v_wready = v_wvalid;
            mem_wr   = v_wvalid;
            w_issue  = v_wvalid;
            if (v_wvalid) mem_src = v_wdata;
          end else begin
            w_issue = 1'b1;
          end
          if (w_issue && w_last) w_state_nxt = VDRAIN;
        end
        VDRAIN:  w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign s_gnt    = w_grant_s;
  assign v_gnt    = w_grant_v;
  assign s_rvalid = r_s_pend;
  assign s_rdata  = (r_s_pend && !r_s_we) ? mem_data : '0;
  assign v_rvalid = r_v_pend;
  assign v_rdata  = r_v_pend ? mem_data : '0;
  assign v_done   = rst_n_in && (r_zdone || (r_state == VDRAIN));

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state    <= IDLE;
      r_last_vec <= 1'b1;
      r_s_we     <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_v_we     <= 1'b0;
      r_v_addr   <= '0;
      r_v_stride <= '0;
      r_v_len    <= '0;
      r_v_cnt    <= '0;
      r_s_pend   <= 1'b0;
      r_v_pend   <= 1'b0;
      r_zdone    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_s_pend <= (r_state == SCALAR);
      r_v_pend <= (r_state == VBURST) && !r_v_we;
      r_zdone  <= w_grant_v && (v_len == '0);
      if (w_grant_s) begin
        r_s_we     <= s_we;
        r_s_addr   <= s_addr;
        r_s_wdata  <= s_wdata;
        r_last_vec <= 1'b0;
      end
      if (w_grant_v) begin
        r_v_we     <= v_we;
        r_v_addr   <= v_base;
        r_v_stride <= v_stride;
        r_v_len    <= v_len;
        r_v_cnt    <= '0;
        r_last_vec <= 1'b1;
      end else if (w_issue) begin
        r_v_addr <= r_v_addr + r_v_stride;
        r_v_cnt  <= r_v_cnt + LP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Transaction-level reference: expected addresses, data and grant timing derived arithmetically.
module tb_mem_port_arbiter;

  logic        clk_in;
  logic        rst_n_in;
  logic        s_req, s_we, s_gnt, s_rvalid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        v_req, v_we, v_gnt, v_wvalid, v_wready, v_rvalid, v_done;
  logic [31:0] v_base, v_stride, v_wdata, v_rdata;
  logic [7:0]  v_len;
  logic        mem_wr;
  logic [31:0] mem_addr, mem_src, mem_data;

  logic [31:0]   ram [0:1023];
  logic [1023:0] ram_set;
  logic          ram_clr, pre_we;
  logic [31:0]   pre_addr, pre_data;
  logic [31:0]   model_mem [logic [31:0]];

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .VLEN_WIDTH(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .v_req(v_req), .v_we(v_we), .v_base(v_base), .v_stride(v_stride), .v_len(v_len),
    .v_gnt(v_gnt), .v_wvalid(v_wvalid), .v_wdata(v_wdata), .v_wready(v_wready),
    .v_rvalid(v_rvalid), .v_rdata(v_rdata), .v_done(v_done),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_src(mem_src), .mem_data(mem_data)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] init_val(input logic [9:0] idx);
    return {12'hC3A, idx, idx} ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_set[a[11:2]] ? ram[a[11:2]] : init_val(a[11:2]);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a[11:2]);
  endfunction

  function automatic logic [31:0] elem_addr(input logic [31:0] base, input logic [31:0] stride, input int i);
    return base + stride * 32'(i);
  endfunction

  // RAM with one-cycle registered read
  always @(posedge clk_in) begin
    mem_data <= ram_rd(mem_addr);
    if (ram_clr) begin
      ram_set <= '0;
    end else if (pre_we) begin
      ram[pre_addr[11:2]]     <= pre_data;
      ram_set[pre_addr[11:2]] <= 1'b1;
    end else if (mem_wr) begin
      ram[mem_addr[11:2]]     <= mem_src;
      ram_set[mem_addr[11:2]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic logic any_out();
    return |{s_gnt, s_rvalid, s_rdata, v_gnt, v_wready, v_rvalid, v_rdata, v_done,
             mem_wr, mem_addr, mem_src};
  endfunction

  task automatic do_scalar(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           output int waited);
    s_req = 1'b1; s_we = we; s_addr = addr; s_wdata = data;
    waited = 0;
    settle();
    while (!s_gnt && waited < 20) begin
      tick(); settle(); waited++;
    end
    check("s_gnt", s_gnt, 1);
    check("gnt_excl", s_gnt & v_gnt, 0);
    check("gnt_mem_wr", mem_wr, 0);
    if (!s_gnt) begin
      s_req = 1'b0; tick(); return;
    end
    tick(); s_req = 1'b0; settle();
    check("s_mem_addr", mem_addr, addr);
    check("s_mem_wr", mem_wr, we);
    if (we) check("s_mem_src", mem_src, data);
    check("s_rvalid_early", s_rvalid, 0);
    tick(); settle();
    check("s_rvalid", s_rvalid, 1);
    check("s_rdata", s_rdata, we ? 32'h0 : model_rd(addr));
    check("s_idle_mem_wr", mem_wr, 0);
    if (we) model_mem[addr] = data;
    tick();
  endtask

  task automatic do_vec(input logic we, input logic [31:0] base, input logic [31:0] stride,
                        input logic [7:0] len, input logic [31:0] stall_mask, output int waited);
    logic [31:0] ea;
    int i;
    int j;
    v_req = 1'b1; v_we = we; v_base = base; v_stride = stride; v_len = len; v_wvalid = 1'b0;
    waited = 0;
    settle();
    while (!v_gnt && waited < 20) begin
      tick(); settle(); waited++;
    end
    check("v_gnt", v_gnt, 1);
    check("gnt_excl", s_gnt & v_gnt, 0);
    check("gnt_mem_wr", mem_wr, 0);
    if (!v_gnt) begin
      v_req = 1'b0; tick(); return;
    end
    tick(); v_req = 1'b0;
    if (len == 8'd0) begin
      settle();
      check("z_done", v_done, 1);
      check("z_mem_wr", mem_wr, 0);
      check("z_rvalid", v_rvalid, 0);
      tick(); settle();
      check("z_done_once", v_done, 0);
      check("z_rvalid2", v_rvalid, 0);
      tick();
      return;
    end
    if (!we) begin
      for (int k = 1; k <= int'(len) + 1; k++) begin
        settle();
        if (k <= int'(len)) begin
          check("vl_addr", mem_addr, elem_addr(base, stride, k - 1));
          check("vl_mem_wr", mem_wr, 0);
        end
        if (k >= 2) begin
          check("vl_rvalid", v_rvalid, 1);
          check("vl_rdata", v_rdata, model_rd(elem_addr(base, stride, k - 2)));
        end else begin
          check("vl_rvalid_early", v_rvalid, 0);
        end
        check("vl_done", v_done, (k == int'(len) + 1));
        tick();
      end
    end else begin
      i = 0;
      j = 0;
      while (i < int'(len) && j < 64) begin
        v_wvalid = (j < 32) ? !stall_mask[j] : 1'b1;
        v_wdata  = $urandom;
        settle();
        if (v_wvalid) begin
          ea = elem_addr(base, stride, i);
          check("vs_addr", mem_addr, ea);
          check("vs_mem_wr", mem_wr, 1);
          check("vs_mem_src", mem_src, v_wdata);
          check("vs_wready", v_wready, 1);
          model_mem[ea] = v_wdata;
          i++;
        end else begin
          check("vs_stall_wr", mem_wr, 0);
          check("vs_stall_wready", v_wready, 0);
        end
        check("vs_done_early", v_done, 0);
        tick();
        j++;
      end
      check("vs_count", i, int'(len));
      v_wvalid = 1'b0;
      settle();
      check("vs_done", v_done, 1);
      check("vs_drain_wr", mem_wr, 0);
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    int exp_c;
    logic exp_v;
    logic [31:0] a;
    logic [31:0] st;
    rst_n_in = 1'b0; ram_clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    v_req = 0; v_we = 0; v_base = '0; v_stride = '0; v_len = '0; v_wvalid = 0; v_wdata = '0;
    tick();
    ram_clr = 1'b0; pre_we = 1'b1; pre_addr = 32'h100; pre_data = 32'hDEADBEEF;
    model_mem[32'h100] = 32'hDEADBEEF;
    tick();
    pre_we = 1'b0;

    // reset held with a pending scalar request, then a scalar read
    s_req = 1'b1; s_addr = 32'h100;
    for (int c = 0; c < 2; c++) begin
      settle();
      check("rst_s_gnt", s_gnt, 0);
      check("rst_outs", any_out(), 0);
      tick();
    end
    rst_n_in = 1'b1;
    do_scalar(1'b0, 32'h100, 32'h0, w);
    check("t1_wait", w, 0);

    // contention from a fresh reset: scalar first, then strict alternation
    rst_n_in = 1'b0; s_req = 1'b0; tick(); rst_n_in = 1'b1;
    s_req = 1; s_we = 0; s_addr = 32'h104;
    v_req = 1; v_we = 0; v_base = 32'h400; v_stride = 32'h4; v_len = 8'd2;
    exp_c = 0; exp_v = 1'b0;
    for (int c = 0; c < 20; c++) begin
      settle();
      check("ct_s_gnt", s_gnt, (c == exp_c) && !exp_v);
      check("ct_v_gnt", v_gnt, (c == exp_c) && exp_v);
      if (c == exp_c) begin
        exp_c = exp_c + (exp_v ? 2 + 2 : 2);
        exp_v = !exp_v;
      end
      tick();
    end
    s_req = 0; v_req = 0;
    for (int c = 0; c < 6; c++) tick();

    // store with one stall cycle before the second element
    do_vec(1'b1, 32'h200, 32'h8, 8'd3, 32'h2, w);
    check("vs_wait", w, 0);
    // load with negative stride wrapping below zero
    do_vec(1'b0, 32'h4, 32'hFFFFFFFC, 8'd3, 32'h0, w);
    check("vw_wait", w, 0);
    // zero-length burst
    do_vec(1'b0, 32'h300, 32'h4, 8'd0, 32'h0, w);
    check("vz_wait", w, 0);
    // read back the stored elements
    do_vec(1'b0, 32'h200, 32'h8, 8'd3, 32'h0, w);

    // reset mid-burst
    v_req = 1; v_we = 0; v_base = 32'h300; v_stride = 32'h4; v_len = 8'd8;
    settle();
    check("mb_v_gnt", v_gnt, 1);
    tick(); v_req = 0; settle();
    check("mb_addr0", mem_addr, 32'h300);
    tick(); settle();
    check("mb_addr1", mem_addr, 32'h304);
    tick(); rst_n_in = 1'b0; settle();
    tick(); rst_n_in = 1'b1; settle();
    check("mb_outs_zero", any_out(), 0);
    tick();
    for (int c = 0; c < 12; c++) begin
      settle();
      check("mb_no_done", v_done, 0);
      check("mb_no_rvalid", v_rvalid, 0);
      check("mb_no_access", {mem_wr, mem_addr}, 0);
      tick();
    end
    do_scalar(1'b1, 32'h308, 32'h12345678, w);
    check("mb_sw_wait", w, 0);
    do_scalar(1'b0, 32'h308, 32'h0, w);
    check("mb_sr_wait", w, 0);

    // randomized single-requester traffic against the memory model
    for (int n = 0; n < 40; n++) begin
      a = 32'h400 + 32'(4 * $urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: do_scalar(1'b0, a, 32'h0, w);
        1: do_scalar(1'b1, a, $urandom, w);
        default: begin
          case ($urandom_range(0, 4))
            0: st = 32'h4;
            1: st = 32'h8;
            2: st = 32'hFFFFFFFC;
            3: st = 32'hFFFFFFF8;
            default: st = 32'hC;
          endcase
          do_vec(1'($urandom_range(0, 1)), a, st, 8'($urandom_range(0, 5)),
                 $urandom & $urandom, w);
        end
      endcase
      check("rnd_wait", w, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the RAM read/write data port (port b) between two requesters:
  - the scalar load/store unit, which issues single-word accesses;
  - the vector load/store unit, which issues strided bursts of word accesses.
- Sits between the cpu core and the ram.
- Arbitrates round-robin, sequences burst addresses, and returns read data aligned to the RAM's one-cycle registered read latency.

Parameters:
- ADDR_WIDTH, 32, byte address width of requesters and RAM port.
- DATA_WIDTH, 32, word width.
- VLEN_WIDTH, 8, width of burst element count.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  reset, synchronous, active-low
- s_req  in  1  scalar request; held with fields stable until s_gnt
- s_we  in  1  scalar write (1) / read (0)
- s_addr  in  ADDR_WIDTH  scalar address
- s_wdata  in  DATA_WIDTH  scalar write data
- s_gnt  out  1  scalar request accepted this cycle (combinational pulse)
- s_rvalid  out  1  scalar completion; read data valid / write acknowledged
- s_rdata  out  DATA_WIDTH  scalar read data
- v_req  in  1  vector burst request; held stable until v_gnt
- v_we  in  1  burst is store (1) / load (0)
- v_base  in  ADDR_WIDTH  element 0 address
- v_stride  in  ADDR_WIDTH  byte stride (two's complement)
- v_len  in  VLEN_WIDTH  element count
- v_gnt  out  1  burst accepted this cycle (combinational pulse)
- v_wvalid  in  1  store element data available
- v_wdata  in  DATA_WIDTH  store element data
- v_wready  out  1  store element consumed this cycle
- v_rvalid  out  1  load element data valid
- v_rdata  out  DATA_WIDTH  load element data
- v_done  out  1  one-cycle pulse, burst complete
- mem_wr  out  1  RAM port write enable
- mem_addr  out  ADDR_WIDTH  RAM port address
- mem_src  out  DATA_WIDTH  RAM write data
- mem_data  in  DATA_WIDTH  RAM read data, valid one cycle after address

Behaviour:
- Reset (rst_n_in=0 at a clock edge):
  - state goes to IDLE.
  - All outputs are 0: s_gnt, s_rvalid, s_rdata, v_gnt, v_wready, v_rvalid, v_rdata, v_done, mem_wr, mem_addr, mem_src.
  - last_grant is set to VECTOR.
- Reset mid-burst:
  - aborts immediately; no further RAM accesses, no v_done.
  - Pending read data is discarded.
- States: IDLE, SCALAR, VBURST, VDRAIN.
- IDLE:
  - mem_wr=0, mem_addr=0.
  - Grant rule:
    - s_req only → s_gnt=1.
    - v_req only → v_gnt=1.
    - Both → grant the requester not equal to last_grant.
  - On grant:
    - latch the request fields;
    - update last_grant;
    - go to SCALAR or VBURST.
  - Exception, v_len=0: v_gnt=1, stay in IDLE, v_done=1 next cycle, no RAM access.
- SCALAR (one cycle):
  - mem_addr=latched s_addr, mem_wr=latched s_we, mem_src=latched s_wdata.
  - Next cycle: s_rvalid=1 and s_rdata=mem_data (reads; s_rdata=0 on writes).
  - Returns to IDLE; the rvalid cycle is an IDLE cycle and may grant again.
- VBURST:
  - Element counter i counts 0..len-1.
  - Element address = base + i*stride, computed incrementally (addr += stride), truncated to ADDR_WIDTH so it wraps modulo 2^ADDR_WIDTH.
  - Loads:
    - one element is issued per cycle (mem_addr=element addr, mem_wr=0);
    - v_rvalid=1 with v_rdata=mem_data the following cycle.
  - Stores:
    - v_wready = v_wvalid.
    - When v_wvalid=1: mem_wr=1, mem_src=v_wdata, element issued, i advances.
    - When v_wvalid=0: mem_wr=0, address held, stall (no timeout).
  - After the last element is issued, go to VDRAIN.
- VDRAIN (one cycle):
  - Loads: the last v_rvalid is asserted here.
  - v_done=1 in this cycle, for loads and stores.
  - Return to IDLE; no grant is made in the VDRAIN cycle.
- Requests arriving during SCALAR, VBURST or VDRAIN wait; no preemption.
- s_gnt and v_gnt are never both 1.
- mem_wr is never 1 outside SCALAR/VBURST.
- Latency:
  - scalar request in IDLE to s_rvalid = 2 cycles.
  - vector burst of N loads: v_gnt to v_done = N+1 cycles.

Test Plan:
- Reset, scalar read:
  - Stimulus: hold rst_n_in=0 two cycles with s_req=1, then release; ram[0x100]=0xDEADBEEF; s_req=1, s_we=0, s_addr=0x100.
  - Required: no grant during reset; s_gnt in cycle 0; mem_addr=0x100 in cycle 1; s_rvalid=1, s_rdata=0xDEADBEEF in cycle 2.
- Contention:
  - Stimulus: s_req and v_req (len 2) both asserted and held continuously.
  - Required: scalar granted first; vector granted at the next IDLE cycle; then scalar again; grants strictly alternate.
- Vector store with stall:
  - Stimulus: base=0x200, stride=8, len=3, data A,B,C; v_wvalid=0 for one cycle before B.
  - Required: writes to 0x200, 0x208, 0x210; mem_wr=0 on the stall cycle; v_done one cycle after the C write.
- Vector load, negative stride with wrap:
  - Stimulus: base=0x4, stride=0xFFFFFFFC (-4), len=3.
  - Required: addresses 0x4, 0x0, 0xFFFFFFFC; three v_rvalid pulses on consecutive cycles; v_done coincident with the third.
- Zero-length burst:
  - Stimulus: v_len=0.
  - Required: v_gnt, v_done the next cycle, mem_wr=0 throughout, no v_rvalid.
- Reset mid-burst:
  - Stimulus: rst_n_in=0 after element 1 of a len-8 load.
  - Required: all outputs 0 the next cycle; no v_done; a fresh scalar request is serviced normally.
